// File: rtl/uart_frame_tx_pkg.sv
// Shared frame definitions for the word-write UART link: byte constants,
// FSM states and the field packing used by both transmit and receive sides.
package uart_frame_tx_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 12;
    localparam int REQ_W     = ADDR_W + DATA_W;
    localparam int ADDR_LO_W = 5;
    localparam int DATA_LO_W = 6;

    localparam logic [7:0] START_BYTE_DEF = 8'hF5;
    localparam logic [7:0] STOP_BYTE_DEF  = 8'hFA;
    localparam logic [7:0] DUMP_BYTE_DEF  = 8'hF6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR_U,
        ST_ADDR_L,
        ST_DATA_U,
        ST_DATA_L,
        ST_STOP,
        ST_DUMP
    } frame_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_req_t;

    // Payload bytes carry at most 6 bits so they can never alias the F5/F6/FA markers.
    function automatic logic [7:0] addr_hi_byte(input word_req_t r);
        return {3'b000, r.addr[ADDR_W-1:ADDR_LO_W]};
    endfunction

    function automatic logic [7:0] addr_lo_byte(input word_req_t r);
        return {3'b000, r.addr[ADDR_LO_W-1:0]};
    endfunction

    function automatic logic [7:0] data_hi_byte(input word_req_t r);
        return {2'b00, r.data[DATA_W-1:DATA_LO_W]};
    endfunction

    function automatic logic [7:0] data_lo_byte(input word_req_t r);
        return {2'b00, r.data[DATA_LO_W-1:0]};
    endfunction

endpackage

// File: rtl/uart_frame_tx_sync_fifo.sv
// Single-clock FIFO holding queued word requests; head word is visible on rd_data.
module sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = wr_en & ~full;
    assign do_pop  = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Turns queued word-write requests into six-byte UART frames and interleaves
// single dump-command bytes between frames.
//
// state   | meaning
// IDLE    | nothing on the wire; picks dump first, then queued frame
// START   | sending frame-open byte
// ADDR_U  | sending addr[9:5]
// ADDR_L  | sending addr[4:0]
// DATA_U  | sending data[11:6]
// DATA_L  | sending data[5:0]
// STOP    | sending frame-close byte; completes the frame
// DUMP    | sending the dump command byte
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] START_BYTE = START_BYTE_DEF,
    parameter logic [7:0] STOP_BYTE  = STOP_BYTE_DEF,
    parameter logic [7:0] DUMP_BYTE  = DUMP_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_addr,
    input  logic [11:0] req_data,
    input  logic        dump_req,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_done,
    output logic        busy,
    output logic [7:0]  frame_count
);

    frame_state_t state;
    frame_state_t state_nxt;
    word_req_t    head;
    word_req_t    frame_q;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic         take_dump;
    logic         sent_q;
    logic         dump_pend_q;
    logic         byte_done;

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (req_valid),
        .wr_data ({req_addr, req_data}),
        .rd_en   (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign req_ready = ~fifo_full;
    assign busy      = ~fifo_empty | (state != ST_IDLE) | dump_pend_q;
    // sent_q is low in the send cycle, so a done coinciding with tx_send is ignored
    assign byte_done = tx_done & sent_q & (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            sent_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sent_q <= (state != ST_IDLE) && (state_nxt == state);
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        take_dump = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dump_pend_q) begin
                    take_dump = 1'b1;
                    state_nxt = ST_DUMP;
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START:  if (byte_done) state_nxt = ST_ADDR_U;
            ST_ADDR_U: if (byte_done) state_nxt = ST_ADDR_L;
            ST_ADDR_L: if (byte_done) state_nxt = ST_DATA_U;
            ST_DATA_U: if (byte_done) state_nxt = ST_DATA_L;
            ST_DATA_L: if (byte_done) state_nxt = ST_STOP;
            ST_STOP:   if (byte_done) state_nxt = ST_IDLE;
            ST_DUMP:   if (byte_done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_send = (state != ST_IDLE) & ~sent_q;
        tx_byte = 8'h00;
        case (state)
            ST_START:  tx_byte = START_BYTE;
            ST_ADDR_U: tx_byte = addr_hi_byte(frame_q);
            ST_ADDR_L: tx_byte = addr_lo_byte(frame_q);
            ST_DATA_U: tx_byte = data_hi_byte(frame_q);
            ST_DATA_L: tx_byte = data_lo_byte(frame_q);
            ST_STOP:   tx_byte = STOP_BYTE;
            ST_DUMP:   tx_byte = DUMP_BYTE;
            default:   tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q     <= '0;
            dump_pend_q <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            if (fifo_pop) begin
                frame_q <= head;
            end
            dump_pend_q <= (dump_pend_q & ~take_dump) | dump_req;
            if ((state == ST_STOP) && byte_done) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a UART responder answers each tx_send with
// tx_done after a programmable delay and a monitor records every byte sent.
module tb_uart_frame_tx;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic [11:0] req_data;
    logic        dump_req;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_done;
    logic        busy;
    logic [7:0]  frame_count;

    logic        resp_done;
    logic        tb_done;
    logic        auto_en;
    logic        early_done;
    int          resp_dly;

    logic [7:0]  cap [0:4095];
    int          cap_n;
    int          dbl_send;
    logic        prev_send;

    int          n_tests;
    int          n_fail;

    assign tx_done = resp_done | tb_done;

    uart_frame_tx #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .dump_req    (dump_req),
        .tx_byte     (tx_byte),
        .tx_send     (tx_send),
        .tx_done     (tx_done),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte monitor
    initial begin
        cap_n     = 0;
        dbl_send  = 0;
        prev_send = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx_send) begin
                if (cap_n < 4096) cap[cap_n] = tx_byte;
                cap_n++;
                if (prev_send) dbl_send++;
            end
            prev_send = tx_send;
        end
    end

    // UART responder
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx_send) begin
                if (early_done) begin
                    resp_done = 1'b1;
                    @(posedge clk);
                    #1 resp_done = 1'b0;
                end
                while (!auto_en) @(negedge clk);
                repeat (resp_dly) @(posedge clk);
                #1 resp_done = 1'b1;
                @(posedge clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [9:0] a, input logic [11:0] d, input int k);
        case (k)
            0: return 8'hF5;
            1: return {3'b000, a[9:5]};
            2: return {3'b000, a[4:0]};
            3: return {2'b00, d[11:6]};
            4: return {2'b00, d[5:0]};
            default: return 8'hFA;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [11:0] d, input int budget, output logic ok);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        ok        = 1'b0;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            if (k >= budget) break;
            @(posedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_sends(input int target, input int budget);
        int k;
        k = 0;
        while (cap_n < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("send_timeout", (cap_n >= target), 1'b1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [9:0] a, input logic [11:0] d);
        for (int k = 0; k < 6; k++) begin
            check(tag, {24'h0, cap[base+k]}, {24'h0, exp_byte(a, d, k)});
        end
    endtask

    logic [9:0]  va [0:4];
    logic [11:0] vd [0:4];

    initial begin
        int   base;
        logic ok;
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        dump_req   = 1'b0;
        tb_done    = 1'b0;
        auto_en    = 1'b1;
        early_done = 1'b0;
        resp_dly   = 10;
        va[0] = 10'h001; vd[0] = 12'h123;
        va[1] = 10'h3FF; vd[1] = 12'hFFF;
        va[2] = 10'h200; vd[2] = 12'h040;
        va[3] = 10'h01F; vd[3] = 12'h03F;
        va[4] = 10'h155; vd[4] = 12'hAAA;

        // reset state
        tick(3);
        @(negedge clk);
        check("rst_tx_send", tx_send, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_frame_count", frame_count, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);

        // single frame, plus START latency
        base = cap_n;
        push(10'h2A5, 12'hABC, 0, ok);
        check("single_accept", ok, 1'b1);
        @(negedge clk);
        check("lat_n1_send", tx_send, 1'b0);
        @(negedge clk);
        check("lat_n2_send", tx_send, 1'b1);
        check("lat_n2_byte", tx_byte, 8'hF5);
        wait_idle(500);
        check("single_nbytes", cap_n - base, 6);
        check("single_b0", cap[base+0], 8'hF5);
        check("single_b1", cap[base+1], 8'h15);
        check("single_b2", cap[base+2], 8'h05);
        check("single_b3", cap[base+3], 8'h2A);
        check("single_b4", cap[base+4], 8'h3C);
        check("single_b5", cap[base+5], 8'hFA);
        check("single_fcount", frame_count, 8'd1);

        // queue fill with tx_done withheld
        auto_en = 1'b0;
        base    = cap_n;
        for (int i = 0; i < 5; i++) begin
            push(va[i], vd[i], 0, ok);
            check("fill_accept", ok, 1'b1);
        end
        check("fill_ready_low", req_ready, 1'b0);
        push(10'h000, 12'h000, 0, ok);
        check("fill_sixth_rejected", ok, 1'b0);
        auto_en = 1'b1;
        wait_idle(3000);
        check("fill_nbytes", cap_n - base, 30);
        for (int i = 0; i < 5; i++) check_frame("fill_frame", base + 6*i, va[i], vd[i]);
        check("fill_fcount", frame_count, 8'd6);

        // dump during ADDR_L with one frame queued
        base = cap_n;
        push(10'h0AA, 12'h555, 0, ok);
        push(10'h311, 12'h0F0, 0, ok);
        wait_sends(base + 3, 200);
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        tick(2);
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        wait_idle(1000);
        check("dump_nbytes", cap_n - base, 13);
        check_frame("dump_frame_a", base, 10'h0AA, 12'h555);
        check("dump_byte", cap[base+6], 8'hF6);
        check_frame("dump_frame_b", base + 7, 10'h311, 12'h0F0);
        check("dump_fcount", frame_count, 8'd8);

        // reset during DATA_U with two requests queued
        base = cap_n;
        push(10'h101, 12'h202, 0, ok);
        push(10'h102, 12'h203, 0, ok);
        push(10'h103, 12'h204, 0, ok);
        wait_sends(base + 4, 200);
        rst = 1'b1;
        #1;
        check("rstmid_tx_send", tx_send, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_fcount", frame_count, 8'h00);
        check("rstmid_ready", req_ready, 1'b1);
        tick(1);
        rst  = 1'b0;
        base = cap_n;
        tick(60);
        check("rstmid_no_bytes", cap_n - base, 0);
        check("rstmid_busy_after", busy, 1'b0);
        check("rstmid_fcount_after", frame_count, 8'h00);

        // tx_done in IDLE and coincident with tx_send are ignored
        tb_done = 1'b1;
        tick(2);
        tb_done = 1'b0;
        tick(2);
        check("idle_done_busy", busy, 1'b0);
        check("idle_done_fcount", frame_count, 8'h00);
        early_done = 1'b1;
        resp_dly   = 3;
        base = cap_n;
        push(10'h2C3, 12'h9E1, 0, ok);
        wait_idle(500);
        early_done = 1'b0;
        check("early_nbytes", cap_n - base, 6);
        check_frame("early_frame", base, 10'h2C3, 12'h9E1);
        check("early_fcount", frame_count, 8'd1);

        // frame_count wrap
        resp_dly = 1;
        for (int i = 0; i < 254; i++) begin
            push(10'(i), 12'(~i), 200, ok);
            if (!ok) check("wrap_push_timeout", ok, 1'b1);
        end
        wait_idle(20000);
        check("wrap_fcount_255", frame_count, 8'd255);
        push(10'h3A5, 12'h5A5, 200, ok);
        wait_idle(500);
        check("wrap_fcount_0", frame_count, 8'd0);

        check("single_cycle_send", dbl_send, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
